// File: rtl/i2s_mic_pkg.sv
// Shared types and arithmetic for the I2S microphone capture path.
package i2s_mic_pkg;

    localparam int DEF_SAMPLE_W = 18;
    localparam int DEF_SLOT_W   = 32;
    localparam logic signed [DEF_SAMPLE_W-1:0] DEFAULT_CAL = 18'sh1C40;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    // Operands are sign-extended by the caller; result is clamped to a w-bit signed range.
    function automatic int sat_add(input int a, input int b, input int w);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo  = -hi - 32'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRCLK generator with slot bit counter; strobes mark the clk cycle in which bclk toggles.
module i2s_clkgen #(
    parameter int SLOT_W  = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      bclk_o,
    output logic                      lrclk_o,
    output logic                      rise_o,
    output logic                      fall_o,
    output logic [$clog2(SLOT_W)-1:0] bit_cnt_o
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = $clog2(SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             tick;

    always_comb begin
        tick    = (div_q == '0);
        div_d   = tick ? DIV_LOAD : div_q - 1'b1;
        bclk_d  = tick ? ~bclk_q : bclk_q;
        cnt_d   = cnt_q;
        lrclk_d = lrclk_q;
        if (tick && bclk_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                lrclk_d = ~lrclk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q   <= DIV_LOAD;
            cnt_q   <= '0;
            bclk_q  <= 1'b1;
            lrclk_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
        end
    end

    assign bclk_o    = bclk_q;
    assign lrclk_o   = lrclk_q;
    assign rise_o    = tick && !bclk_q;
    assign fall_o    = tick && bclk_q;
    assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/i2s_mic_capture.sv
// I2S mono mic front end: calibrated capture, sample history and windowed hand-off.
// Define DC_TRACK_EN to replace the fixed CAL_OFFSET with a running DC tracker.
module i2s_mic_capture
    import i2s_mic_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int CLK_DIV  = 2,
    parameter int DEPTH    = 16,
    parameter int HOP      = 16,
    parameter logic signed [SAMPLE_W-1:0] CAL_OFFSET = DEFAULT_CAL,
    parameter int DC_SHIFT = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dout,
    output logic                      bclk,
    output logic                      lrclk,
    input  logic                      ch_sel,
    output logic [SAMPLE_W-1:0]       sample,
    output logic                      sample_valid,
    output logic [DEPTH*SAMPLE_W-1:0] win_data,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic                      overrun
);

    localparam int CNT_W = $clog2(SLOT_W);
    localparam int HOP_W = $clog2(HOP + 1);

    if (SLOT_W <= SAMPLE_W || CLK_DIV < 1 || HOP < 1 || HOP > DEPTH || DEPTH < 2 || DC_SHIFT < 1)
    begin : g_param_check
        $error("i2s_mic_capture: illegal parameter combination");
    end

    logic             rise, fall, frame_start, capture, complete;
    logic [CNT_W-1:0] bit_cnt;

    i2s_clkgen #(
        .SLOT_W (SLOT_W),
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .bclk_o   (bclk),
        .lrclk_o  (lrclk),
        .rise_o   (rise),
        .fall_o   (fall),
        .bit_cnt_o(bit_cnt)
    );

    logic [SAMPLE_W-2:0]        shift_q, shift_d;
    slot_e                      ch_lat_q, ch_lat_d;
    logic [SAMPLE_W-1:0]        sample_q, sample_d;
    logic                       valid_q, valid_d;
    logic [DEPTH*SAMPLE_W-1:0]  hist_q, hist_d;
    logic [DEPTH*SAMPLE_W-1:0]  win_q, win_d;
    logic                       win_valid_q, win_valid_d;
    logic                       overrun_q, overrun_d;
    logic [HOP_W-1:0]           hop_q, hop_d;
    logic signed [SAMPLE_W-1:0] raw;
    logic [SAMPLE_W-1:0]        cal;

    // The final data bit is taken straight from dout so the sample completes on its own edge.
    always_comb begin
        raw         = {shift_q, dout};
        frame_start = fall && lrclk && (bit_cnt == CNT_W'(SLOT_W - 1));
        capture     = rise && (bit_cnt >= CNT_W'(1)) && (bit_cnt <= CNT_W'(SAMPLE_W));
        complete    = rise && (bit_cnt == CNT_W'(SAMPLE_W)) && (slot_e'(lrclk) == ch_lat_q);
    end

`ifdef DC_TRACK_EN
    localparam int DC_W = SAMPLE_W + DC_SHIFT;
    logic signed [DC_W-1:0] dc_q, dc_d;
    logic signed [DC_W:0]   dc_err;

    always_comb begin
        cal    = SAMPLE_W'(sat_add(int'(raw), -int'($signed(dc_q[DC_W-1 -: SAMPLE_W])), SAMPLE_W));
        dc_err = ((DC_W+1)'(raw) <<< DC_SHIFT) - (DC_W+1)'(dc_q);
        dc_d   = complete ? dc_q + DC_W'(dc_err >>> DC_SHIFT) : dc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dc_q <= '0;
        end else begin
            dc_q <= dc_d;
        end
    end
`else
    always_comb begin
        cal = SAMPLE_W'(sat_add(int'(raw), int'(CAL_OFFSET), SAMPLE_W));
    end
`endif

    always_comb begin
        shift_d     = capture ? {shift_q[SAMPLE_W-3:0], dout} : shift_q;
        ch_lat_d    = frame_start ? slot_e'(ch_sel) : ch_lat_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        hist_d      = hist_q;
        hop_d       = hop_q;
        win_d       = win_q;
        win_valid_d = win_valid_q && !win_ready;
        overrun_d   = overrun_q;
        if (complete) begin
            sample_d = cal;
            valid_d  = 1'b1;
            hist_d   = {hist_q[(DEPTH-1)*SAMPLE_W-1:0], cal};
            hop_d    = hop_q + 1'b1;
        end
        // Snapshot runs one cycle after the HOP-th push; never coincides with a push.
        if (hop_q == HOP_W'(HOP)) begin
            hop_d = '0;
            if (!win_valid_q || win_ready) begin
                win_d       = hist_q;
                win_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q     <= '0;
            ch_lat_q    <= SLOT_LEFT;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            hist_q      <= '0;
            hop_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            ch_lat_q    <= ch_lat_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            hist_q      <= hist_d;
            hop_q       <= hop_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign win_data     = win_q;
    assign win_valid    = win_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Randomised bench for i2s_mic_capture: I2S mic model, scoreboard queues and a decoupled monitor.
module tb_i2s_mic_capture;

    localparam int SW      = 18;
    localparam int SLOT_W  = 32;
    localparam int CLK_DIV = 2;
    localparam int DEPTH   = 4;
    localparam int HOP     = 4;
    localparam int CAL     = 7232;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic dout = 1'b0;
    logic ch_sel = 1'b0;
    logic win_ready = 1'b1;
    logic bclk, lrclk, sample_valid, win_valid, overrun;
    logic [SW-1:0]       sample;
    logic [DEPTH*SW-1:0] win_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2s_mic_capture #(
        .SAMPLE_W  (SW),
        .SLOT_W    (SLOT_W),
        .CLK_DIV   (CLK_DIV),
        .DEPTH     (DEPTH),
        .HOP       (HOP),
        .CAL_OFFSET(18'sh1C40),
        .DC_SHIFT  (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dout        (dout),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .ch_sel      (ch_sel),
        .sample      (sample),
        .sample_valid(sample_valid),
        .win_data    (win_data),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .overrun     (overrun)
    );

    // Reference: interpret 18-bit word as signed, add offset, clamp, re-encode.
    function automatic int model_cal(input int raw);
        int v;
        v = (raw >= 131072) ? raw - 262144 : raw;
        v = v + CAL;
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
        return v & 32'h3FFFF;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- mic model and stimulus ----------------
    int          idx = 0;
    logic        prev_lr = 1'b1;
    bit          started = 1'b0;
    logic        model_ch = 1'b0;
    logic [17:0] cur_word = '0;
    bit          chsel_rand = 1'b0;
    int          exp_q[$];
    int          dir_q[$];

    always @(negedge bclk) begin
        if (reset === 1'b1) begin
            if (lrclk !== prev_lr) begin
                if (prev_lr && !lrclk) begin
                    started  = 1'b1;
                    model_ch = ch_sel;
                end
                prev_lr = lrclk;
                idx     = 0;
                if (started && lrclk == model_ch) begin
                    if (dir_q.size() > 0) cur_word = 18'(dir_q.pop_front());
                    else                  cur_word = 18'($urandom);
                    exp_q.push_back(model_cal(int'(cur_word)));
                end else begin
                    cur_word = 18'($urandom);
                end
            end else begin
                idx++;
            end
            if (idx >= 1 && idx <= SW) dout = cur_word[5'(SW - idx)];
            else                       dout = 1'($urandom);
            if (chsel_rand && idx == 10) ch_sel = 1'($urandom);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int                  n_seen = 0;
    int                  n_win = 0;
    int                  mcount = 0;
    int                  mh[$];
    logic [DEPTH*SW-1:0] win_q[$];
    logic [DEPTH*SW-1:0] last_win = '0;
    bit                  pend = 1'b0;
    bit                  exp_overrun = 1'b0;

    always @(negedge clk) begin
        int e;
        if (reset === 1'b1) begin
            if (sample_valid === 1'b1) begin
                n_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample_unexpected: got %0h, expected no sample", sample);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", 128'(sample), 128'(e));
                    mh.push_back(e);
                    if (mh.size() > DEPTH) void'(mh.pop_front());
                    mcount++;
                    if (mcount == HOP) begin
                        mcount = 0;
                        if (pend) begin
                            exp_overrun = 1'b1;
                        end else begin
                            for (int i = 0; i < DEPTH; i++)
                                last_win[i*SW +: SW] = SW'(mh[mh.size()-1-i]);
                            win_q.push_back(last_win);
                            pend = 1'b1;
                        end
                    end
                end
            end
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                n_win++;
                pend = 1'b0;
                if (win_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL window_unexpected: got %0h, expected no window", win_data);
                end else begin
                    check("window", 128'(win_data), 128'(win_q.pop_front()));
                end
            end
        end
    end

    // ---------------- sequencing ----------------
    task automatic wait_n(input int target);
        int b;
        b = 0;
        while (n_seen < target && b < 20000) begin
            @(posedge clk);
            b++;
        end
        check_i("samples_reached", n_seen, target);
    endtask

    task automatic cycles_until(input bit is_lr, input logic val, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((is_lr ? lrclk : bclk) !== val) && n < 2000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"}, 128'(bclk), 128'(1));
        check({tag, "_lrclk"}, 128'(lrclk), 128'(1));
        check({tag, "_sample"}, 128'(sample), 128'(0));
        check({tag, "_sample_valid"}, 128'(sample_valid), 128'(0));
        check({tag, "_win_data"}, 128'(win_data), 128'(0));
        check({tag, "_win_valid"}, 128'(win_valid), 128'(0));
        check({tag, "_overrun"}, 128'(overrun), 128'(0));
    endtask

    initial begin
        int n;
        int b;
        dir_q = '{32'h1FFFF, 32'h3E3C0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        cycles_until(1'b0, 1'b0, n);
        check_i("first_bclk_fall", n, CLK_DIV);
        cycles_until(1'b0, 1'b1, n);
        check_i("bclk_low_half", n, CLK_DIV);
        cycles_until(1'b0, 1'b0, n);
        check_i("bclk_high_half", n, CLK_DIV);
        cycles_until(1'b1, 1'b0, n);
        cycles_until(1'b1, 1'b1, n);
        check_i("lrclk_half_a", n, 2 * SLOT_W * CLK_DIV);
        cycles_until(1'b1, 1'b0, n);
        check_i("lrclk_half_b", n, 2 * SLOT_W * CLK_DIV);

        chsel_rand = 1'b1;
        wait_n(16);
        check("overrun_clear", 128'(overrun), 128'(exp_overrun));
        repeat (4) @(posedge clk);
        #1 win_ready = 1'b0;

        wait_n(20);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("win_valid_held", 128'(win_valid), 128'(1));
        check("overrun_before_drop", 128'(overrun), 128'(exp_overrun));

        wait_n(24);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("overrun_set", 128'(overrun), 128'(exp_overrun));
        check("win_valid_after_drop", 128'(win_valid), 128'(1));
        check("win_data_held", 128'(win_data), 128'(last_win));

        @(posedge clk);
        #1 win_ready = 1'b1;
        @(posedge clk);
        #1 win_ready = 1'b0;
        @(negedge clk);
        check("win_valid_after_accept", 128'(win_valid), 128'(0));
        check_i("windows_transferred", n_win, 5);

        @(posedge clk);
        #1;
        win_ready  = 1'b1;
        chsel_rand = 1'b0;
        ch_sel     = 1'b0;

        // Reset in the middle of a left slot's data bits.
        b = 0;
        while (!(started && prev_lr == 1'b0 && idx == 9) && b < 5000) begin
            @(posedge clk);
            b++;
        end
        check_i("reach_mid_slot", (b < 5000) ? 1 : 0, 1);
        #1 reset = 1'b0;
        exp_q.delete();
        win_q.delete();
        mh.delete();
        mcount      = 0;
        pend        = 1'b0;
        exp_overrun = 1'b0;
        started     = 1'b0;
        prev_lr     = 1'b1;
        idx         = 0;
        cur_word    = '0;
        dir_q.push_back(32'h2A5A5);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");

        n = n_seen;
        wait_n(n + 2);
        check("overrun_after_reset", 128'(overrun), 128'(exp_overrun));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
